// File: rtl/frame_burst_writer.sv
// -----------------------------------------------------------------------------
// frame_burst_writer
//   Drains RGB565 words from the capture FIFO read port into a small line
//   buffer, then writes them to the SDRAM frame buffer as one fixed-length
//   Avalon-MM write burst. Tracks the frame-buffer word address, wraps it
//   once per frame and pulses frame_start when the first beat of a frame's
//   first burst is accepted.
//
// Ports
//   clk              in   single clock (FIFO read-clock domain)
//   nReset           in   asynchronous active-low reset
//   enable           in   permits starting new bursts
//   fifo_avail       in   FIFO holds >= BURST_LEN words
//   fifo_q           in   FIFO read data, valid 1 clk after fifo_rdreq
//   fifo_rdreq       out  FIFO read strobe
//   mem_address      out  burst start word address
//   mem_burstcount   out  BURST_LEN while mem_write, else 0
//   mem_writedata    out  current beat data
//   mem_write        out  write request
//   mem_waitrequest  in   slave stall
//   frame_start      out  1-clk pulse after beat 0 of an address-0 burst
//   busy             out  high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module frame_burst_writer #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned ADDR_W     = 22
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              enable,
  input  logic              fifo_avail,
  input  logic [15:0]       fifo_q,
  output logic              fifo_rdreq,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_burstcount,
  output logic [15:0]       mem_writedata,
  output logic              mem_write,
  input  logic              mem_waitrequest,
  output logic              frame_start,
  output logic              busy
);

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned BCNT_W      = 4;
  localparam int unsigned FRAME_WORDS = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned CNT_W       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BURST_LEN - 1);
  localparam logic [BCNT_W-1:0] BCNT_FULL = BCNT_W'(BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  // State and counters
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;       // rdreq index in FETCH, beat index in WRITE
  logic [ADDR_W-1:0] r_addr;      // start address of the next burst
  logic              r_rd_d;      // rdreq delayed: fifo_q holds a requested word
  logic [CNT_W-1:0]  r_rd_idx;    // buffer slot for that word

  // Registered outputs
  logic              r_fifo_rdreq;
  logic [ADDR_W-1:0] r_mem_address;
  logic [BCNT_W-1:0] r_mem_burstcount;
  logic [DATA_W-1:0] r_mem_writedata;
  logic              r_mem_write;
  logic              r_frame_start;
  logic              r_busy;

  // Burst line buffer
  logic [DATA_W-1:0] r_buf [BURST_LEN];

  // Next-state values
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_rdreq_nxt;
  logic [ADDR_W-1:0] w_mem_address_nxt;
  logic [BCNT_W-1:0] w_burstcount_nxt;
  logic [DATA_W-1:0] w_writedata_nxt;
  logic              w_write_nxt;
  logic              w_frame_start_nxt;
  logic              w_busy_nxt;

  logic [CNT_W-1:0]  w_cnt_inc;
  logic [ADDR_W:0]   w_addr_sum;
  logic [ADDR_W-1:0] w_addr_wrap;

  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  // One extra bit so the wrap compare cannot be fooled by ADDR_W overflow
  assign w_addr_sum  = {1'b0, r_addr} + (ADDR_W+1)'(BURST_LEN);
  assign w_addr_wrap = (w_addr_sum >= (ADDR_W+1)'(FRAME_WORDS)) ? '0
                                                               : w_addr_sum[ADDR_W-1:0];

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_addr_nxt        = r_addr;
    w_mem_address_nxt = r_mem_address;
    w_writedata_nxt   = r_mem_writedata;
    w_frame_start_nxt = 1'b0;
    w_rdreq_nxt       = 1'b0;
    w_write_nxt       = 1'b0;
    w_burstcount_nxt  = '0;
    w_busy_nxt        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (enable && fifo_avail) begin
          w_state_nxt = S_FETCH;
          w_cnt_nxt   = '0;
        end
      end
      S_FETCH: begin
        // fifo_avail is not re-checked: the words were guaranteed at entry
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      S_DRAIN: begin
        // Last word lands this cycle; slot 0 is long since valid
        w_state_nxt       = S_WRITE;
        w_cnt_nxt         = '0;
        w_mem_address_nxt = r_addr;
        w_writedata_nxt   = r_buf[0];
      end
      S_WRITE: begin
        // mem_write is high for the whole of WRITE, so acceptance is !waitrequest
        if (!mem_waitrequest) begin
          w_frame_start_nxt = (r_cnt == '0) && (r_addr == '0);
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_addr_nxt  = w_addr_wrap;
          end else begin
            w_cnt_nxt       = w_cnt_inc;
            w_writedata_nxt = r_buf[w_cnt_inc];
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // Strobes follow the state being entered so they stay registered
    w_rdreq_nxt      = (w_state_nxt == S_FETCH);
    w_write_nxt      = (w_state_nxt == S_WRITE);
    w_burstcount_nxt = w_write_nxt ? BCNT_FULL : '0;
    w_busy_nxt       = (w_state_nxt != S_IDLE);
  end

  // State, counters and output registers
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_addr           <= '0;
      r_rd_d           <= 1'b0;
      r_rd_idx         <= '0;
      r_fifo_rdreq     <= 1'b0;
      r_mem_address    <= '0;
      r_mem_burstcount <= '0;
      r_mem_writedata  <= '0;
      r_mem_write      <= 1'b0;
      r_frame_start    <= 1'b0;
      r_busy           <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_cnt            <= w_cnt_nxt;
      r_addr           <= w_addr_nxt;
      r_rd_d           <= r_fifo_rdreq;
      r_rd_idx         <= r_cnt;
      r_fifo_rdreq     <= w_rdreq_nxt;
      r_mem_address    <= w_mem_address_nxt;
      r_mem_burstcount <= w_burstcount_nxt;
      r_mem_writedata  <= w_writedata_nxt;
      r_mem_write      <= w_write_nxt;
      r_frame_start    <= w_frame_start_nxt;
      r_busy           <= w_busy_nxt;
    end
  end

  // Line buffer capture: word k arrives the clock after its rdreq
  always_ff @(posedge clk) begin
    if (r_rd_d) begin
      r_buf[r_rd_idx] <= fifo_q;
    end
  end

  assign fifo_rdreq     = r_fifo_rdreq;
  assign mem_address    = r_mem_address;
  assign mem_burstcount = r_mem_burstcount;
  assign mem_writedata  = r_mem_writedata;
  assign mem_write      = r_mem_write;
  assign frame_start    = r_frame_start;
  assign busy           = r_busy;

endmodule
